// File: rtl/seq_pkg.sv
// Shared constants and next-state function for the serial sequence detector
// that feeds the 3-bit Mealy output decoder.
package seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S0 = 3'b000;
  localparam logic [STATE_W-1:0] S1 = 3'b001;
  localparam logic [STATE_W-1:0] S2 = 3'b010;
  localparam logic [STATE_W-1:0] S3 = 3'b011;
  localparam logic [STATE_W-1:0] S4 = 3'b100;
  localparam logic [STATE_W-1:0] S5 = 3'b101;

  // Encodings 110/111 are unreachable and fall back to S0.
  function automatic logic [STATE_W-1:0] seq_next(input logic [STATE_W-1:0] state,
                                                  input logic bit_in);
    logic [STATE_W-1:0] nxt;
    nxt = S0;
    case (state)
      S0:      nxt = bit_in ? S3 : S1;
      S1:      nxt = bit_in ? S2 : S1;
      S2:      nxt = bit_in ? S3 : S4;
      S3:      nxt = bit_in ? S3 : S4;
      S4:      nxt = bit_in ? S5 : S1;
      S5:      nxt = bit_in ? S3 : S4;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_state_driver_next_state.sv
// Purely combinational next-state table of the sequence detector.
module seq_next_state
  import seq_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               bit_in,
  output logic [STATE_W-1:0] next_state
);

  assign next_state = seq_next(state, bit_in);

endmodule

// File: rtl/seq_state_driver.sv
// Sequence detector front end: accepts serial bits and presents each registered
// {state, bit} pair to the Mealy decoder. Optional SEQ_ERR_CHECK_EN adds a sticky illegal-state flag.
module seq_state_driver
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               i,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               err,
  output logic [STATE_W-1:0] state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and a held valid keeps its data stable.
  logic               acc;
  logic               illegal;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_nxt;
  logic [STATE_W-1:0] out_state_q;

  assign in_ready  = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign illegal   = (state_q == 3'b110) || (state_q == 3'b111);
  assign state_dbg = state_q;
  assign {s2, s1, s0} = out_state_q;

  seq_next_state u_next (
    .state      (state_q),
    .bit_in     (in_bit),
    .next_state (state_nxt)
  );

  // Detector state: clear and the illegal-state recovery override any accept.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= S0;
    end
`ifdef SEQ_ERR_CHECK_EN
    else if (illegal) begin
      state_q <= S0;
    end
`endif
    else if (acc) begin
      state_q <= state_nxt;
    end
  end

  // One-entry output register; it still captures the pre-clear state when clr
  // and an accept coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_state_q <= S0;
      i           <= 1'b0;
    end else if (acc) begin
      out_valid   <= 1'b1;
      out_state_q <= state_q;
      i           <= in_bit;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_cnt <= '0;
    end else if (acc && (bit_cnt != {CNT_W{1'b1}})) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef SEQ_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_seq_state_driver.sv
// Directed self-checking bench for seq_state_driver (default and CNT_W=2 instances).
module tb_seq_state_driver;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_bit, out_ready;
  logic       in_ready, out_valid, s2, s1, s0, out_i, err;
  logic [15:0] bit_cnt;
  logic [2:0] state_dbg;
  logic       in_ready_b, out_valid_b, s2_b, s1_b, s0_b, out_i_b, err_b;
  logic [1:0] bit_cnt_b;
  logic [2:0] state_dbg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_state_driver #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready),
    .s2(s2), .s1(s1), .s0(s0), .i(out_i), .bit_cnt(bit_cnt), .err(err),
    .state_dbg(state_dbg)
  );

  seq_state_driver #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bit(in_bit), .out_valid(out_valid_b), .out_ready(out_ready),
    .s2(s2_b), .s1(s1_b), .s0(s0_b), .i(out_i_b), .bit_cnt(bit_cnt_b), .err(err_b),
    .state_dbg(state_dbg_b)
  );

  // Output bundle {out_valid, s2, s1, s0, i} and the decoder output y.
  logic [4:0] obs;
  logic       y;
  assign obs = {out_valid, s2, s1, s0, out_i};
  assign y   = ({s2, s1, s0} == 3'b010 && !out_i) || ({s2, s1, s0} == 3'b101 && out_i);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'($urandom_range(0, 1));
    in_bit = 1'($urandom_range(0, 1)); out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({obs, bit_cnt, err, state_dbg} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {obs, bit_cnt, err, state_dbg});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stream_010();
    logic [2:0] bits;
    logic [4:0] exp_obs [3];
    bits = 3'b010;
    exp_obs[0] = 5'b1_000_0; exp_obs[1] = 5'b1_001_1; exp_obs[2] = 5'b1_010_0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_bit = bits[2-k];
      tick();
      checks++;
      if (obs !== exp_obs[k]) begin
        errors++;
        $display("FAIL stream010_pair%0d: got %b expected %b", k, obs, exp_obs[k]);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (y !== 1'b1 || bit_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stream010_y_cnt: got y=%b cnt=%0d expected y=1 cnt=3", y, bit_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || state_dbg !== 3'b100) begin
      errors++;
      $display("FAIL stream010_drain: got valid=%b state=%b expected 0 100", out_valid, state_dbg);
    end
  endtask

  task automatic test_stream_1011();
    logic [3:0] bits;
    logic [4:0] exp_obs [4];
    bits = 4'b1011;
    exp_obs[0] = 5'b1_000_1; exp_obs[1] = 5'b1_011_0;
    exp_obs[2] = 5'b1_100_1; exp_obs[3] = 5'b1_101_1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (state_dbg !== 3'b000 || bit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_idle: got state=%b cnt=%0d expected 000 0", state_dbg, bit_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_bit = bits[3-k];
      tick();
      checks++;
      if (obs !== exp_obs[k]) begin
        errors++;
        $display("FAIL stream1011_pair%0d: got %b expected %b", k, obs, exp_obs[k]);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (y !== 1'b1 || state_dbg !== 3'b011 || bit_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stream1011_end: got y=%b state=%b cnt=%0d expected 1 011 4", y, state_dbg, bit_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // State S3: accept bit 0 while the consumer stalls.
    out_ready = 1'b0; in_valid = 1'b1; in_bit = 1'b0;
    tick();
    in_bit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || obs !== 5'b1_011_0 || bit_cnt !== 16'd5) begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy=%b obs=%b cnt=%0d expected 0 10110 5", k, in_ready, obs, bit_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== 5'b1_100_1 || bit_cnt !== 16'd6) begin
      errors++;
      $display("FAIL stall_release_pair: got obs=%b cnt=%0d expected 11001 6", obs, bit_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || bit_cnt !== 16'd6 || state_dbg !== 3'b101) begin
      errors++;
      $display("FAIL stall_no_dup: got valid=%b cnt=%0d state=%b expected 0 6 101", out_valid, bit_cnt, state_dbg);
    end
  endtask

  task automatic test_clr_with_acc();
    in_valid = 1'b1; in_bit = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 3'b100) begin
      errors++;
      $display("FAIL clracc_setup: got state=%b expected 100", state_dbg);
    end
    clr = 1'b1; in_bit = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs !== 5'b1_100_1 || state_dbg !== 3'b000 || bit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clracc_result: got obs=%b state=%b cnt=%0d expected 11001 000 0", obs, state_dbg, bit_cnt);
    end
    tick();
  endtask

  task automatic test_rst_mid_transfer();
    out_ready = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++;
    if (obs !== 5'b0 || bit_cnt !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_drop: got obs=%b cnt=%0d rdy=%b expected 0 0 1", obs, bit_cnt, in_ready);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_small;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_bit = 1'($urandom_range(0, 1));
      tick();
      exp_small = (k > 3) ? 2'd3 : 2'(k);
      checks++;
      if (bit_cnt_b !== exp_small || bit_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL saturate_%0d: got small=%0d big=%0d expected %0d %0d", k, bit_cnt_b, bit_cnt, exp_small, k);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef SEQ_ERR_CHECK_EN
  task automatic test_err_check();
    force dut.state_q = 3'b111;
    #1;
    release dut.state_q;
    tick();
    checks++;
    if (err !== 1'b1 || state_dbg !== 3'b000) begin
      errors++;
      $display("FAIL err_set: got err=%b state=%b expected 1 000", err, state_dbg);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream_010();
    test_stream_1011();
    test_back_to_back();
    test_clr_with_acc();
    test_rst_mid_transfer();
    test_saturate();
`ifdef SEQ_ERR_CHECK_EN
    test_err_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
